// File: rtl/mips_pipe_core.sv
// mips_pipe_core: 5-stage MIPS pipeline (IF/ID/EX/MEM/WB) with load-use interlock and branch flush.
// Define CPU_FORWARD_EN for EX-stage forwarding; otherwise ID interlocks on every pending writer.
module mips_pipe_core #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clock,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic               dmem_we,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  output logic               wb_valid,
  output logic [4:0]         wb_addr,
  output logic [31:0]        wb_data,
  output logic [31:0]        retire_cnt
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;
  typedef struct packed {
    logic        valid, reg_write, mem_read, mem_write, beq, bne, use_imm;
    logic [2:0]  alu_op;
`ifdef CPU_FORWARD_EN
    logic [4:0]  rs, rt;
`endif
    logic [4:0]  dest;
    logic [31:0] pc, a, b, imm;
  } idex_t;
  typedef struct packed {
    logic        valid, reg_write, mem_read, mem_write;
    logic [4:0]  dest;
    logic [31:0] alu, sd;
  } exmem_t;
  typedef struct packed {
    logic        valid, reg_write;
    logic [4:0]  dest;
    logic [31:0] data;
  } memwb_t;

  ifid_t       ifid;
  idex_t       idex, id_d;
  exmem_t      exmem;
  memwb_t      memwb;
  logic [31:0] pc;
  logic [31:0] rf [32];
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic        r_ok, uses_rt, stall, taken;
  logic [31:0] fa, fb, bv, alu, target;

  assign op = ifid.instr[31:26];
  assign rs = ifid.instr[25:21];
  assign rt = ifid.instr[20:16];
  assign rd = ifid.instr[15:11];
  assign fn = ifid.instr[5:0];
  assign r_ok = op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
  assign uses_rt = r_ok || op == 6'h2B || op == 6'h04 || op == 6'h05;

  always_comb begin
    id_d = '0;
    id_d.valid = ifid.valid;
    id_d.dest = op == 6'h00 ? rd : rt;
    id_d.reg_write = (r_ok || op == 6'h08 || op == 6'h23) && id_d.dest != 5'd0;
    id_d.mem_read = op == 6'h23;
    id_d.mem_write = op == 6'h2B;
    id_d.beq = op == 6'h04;
    id_d.bne = op == 6'h05;
    id_d.use_imm = op == 6'h08 || op == 6'h23 || op == 6'h2B;
    id_d.alu_op = !r_ok ? 3'd0 : fn == 6'h22 ? 3'd1 : fn == 6'h24 ? 3'd2 : fn == 6'h25 ? 3'd3 : fn == 6'h2A ? 3'd4 : 3'd0;
    id_d.pc = ifid.pc;
    id_d.imm = {{16{ifid.instr[15]}}, ifid.instr[15:0]};
    // WB writes land at the closing edge, so the ID read sees them through this bypass
    id_d.a = wb_valid && wb_addr == rs ? wb_data : rf[rs];
    id_d.b = wb_valid && wb_addr == rt ? wb_data : rf[rt];
`ifdef CPU_FORWARD_EN
    id_d.rs = rs;
    id_d.rt = rt;
`endif
  end

`ifdef CPU_FORWARD_EN
  assign fa = exmem.reg_write && exmem.dest == idex.rs ? exmem.alu :
              memwb.reg_write && memwb.dest == idex.rs ? memwb.data : idex.a;
  assign fb = exmem.reg_write && exmem.dest == idex.rt ? exmem.alu :
              memwb.reg_write && memwb.dest == idex.rt ? memwb.data : idex.b;
  assign stall = ifid.valid && idex.mem_read && idex.dest != 5'd0 &&
                 (idex.dest == rs || (uses_rt && idex.dest == rt));
`else
  assign fa = idex.a;
  assign fb = idex.b;
  assign stall = ifid.valid && (
    (rs != 5'd0 && ((idex.reg_write && idex.dest == rs) || (exmem.reg_write && exmem.dest == rs))) ||
    (uses_rt && rt != 5'd0 && ((idex.reg_write && idex.dest == rt) || (exmem.reg_write && exmem.dest == rt))));
`endif

  assign bv = idex.use_imm ? idex.imm : fb;
  assign alu = idex.alu_op == 3'd1 ? fa - bv :
               idex.alu_op == 3'd2 ? fa & bv :
               idex.alu_op == 3'd3 ? fa | bv :
               idex.alu_op == 3'd4 ? {31'd0, $signed(fa) < $signed(bv)} : fa + bv;
  assign taken = (idex.beq && fa == fb) || (idex.bne && fa != fb);
  assign target = idex.pc + 32'd4 + {idex.imm[29:0], 2'b00};

  assign imem_addr = pc[IMEM_AW+1:2];
  assign dmem_addr = exmem.alu[DMEM_AW+1:2];
  assign dmem_we = exmem.mem_write;
  assign dmem_wdata = exmem.sd;
  assign wb_valid = memwb.reg_write;
  assign wb_addr = memwb.dest;
  assign wb_data = memwb.data;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pc <= RESET_PC;
      ifid <= '0;
      idex <= '0;
      exmem <= '0;
      memwb <= '0;
      retire_cnt <= '0;
    end else begin
      // a taken branch overrides a concurrent stall: the stalled ID instruction is dropped
      if (taken) begin
        pc <= target;
        ifid <= '0;
        idex <= '0;
      end else if (stall) begin
        idex <= '0;
      end else begin
        pc <= pc + 32'd4;
        ifid <= ifid_t'{1'b1, pc, imem_rdata};
        idex <= id_d;
      end
      exmem <= exmem_t'{idex.valid, idex.reg_write, idex.mem_read, idex.mem_write, idex.dest, alu, fb};
      memwb <= memwb_t'{exmem.valid, exmem.reg_write, exmem.dest, exmem.mem_read ? dmem_rdata : exmem.alu};
      retire_cnt <= retire_cnt + {31'd0, memwb.valid};
    end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_valid) begin
      rf[wb_addr] <= wb_data;
    end
endmodule

// File: tb/tb_mips_pipe_core.sv
// tb_mips_pipe_core: directed hazard scenarios plus random programs checked against an ISA-level model.
module tb_mips_pipe_core;
`ifdef CPU_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int L = 24;

  logic        clock = 1'b0, reset = 1'b0;
  logic [7:0]  imem_addr, dmem_addr;
  logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, wb_data, retire_cnt;
  logic        dmem_we, wb_valid;
  logic [4:0]  wb_addr;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [31:0] ref_mem [256];
  int edges = 0, we_cnt = 0, total = 0, bad = 0, exp_n = 0;
  int log_a[$], log_d[$], log_c[$], log_r[$], exp_a[$], exp_d[$];
  bit mark_seen = 1'b0;

  always #5 clock = ~clock;

  mips_pipe_core dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .retire_cnt(retire_cnt)
  );

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clock or posedge reset)
    if (reset) edges <= 0;
    else edges <= edges + 1;

  always @(posedge clock)
    if (dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
      we_cnt <= we_cnt + 1;
    end

  always @(negedge clock)
    if (!reset && wb_valid) begin
      log_a.push_back(int'(wb_addr));
      log_d.push_back(int'(wb_data));
      log_c.push_back(edges + 1);
      log_r.push_back(int'(retire_cnt));
      if (wb_addr == 5'd31) mark_seen = 1'b1;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] f, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic prep();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      imem[i] = '0;
      dmem[i] = '0;
    end
  endtask

  task automatic start();
    reset = 1'b1;
    @(negedge clock);
    check("rst_imem_addr", imem_addr, 8'd0);
    check("rst_dmem_we", dmem_we, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_addr", wb_addr, 5'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_retire", retire_cnt, 32'd0);
    log_a.delete(); log_d.delete(); log_c.delete(); log_r.delete();
    mark_seen = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic exp_wr(input string tag, input int i, input int a, input int d, input int c);
    check({tag, "_addr"}, i < log_a.size() ? log_a[i] : -1, a);
    check({tag, "_data"}, i < log_d.size() ? log_d[i] : -1, d);
    check({tag, "_cycle"}, i < log_c.size() ? log_c[i] : -1, c);
  endtask

  // ISA-level interpreter: executes the program word by word until the marker at index L
  task automatic ref_run();
    logic [31:0] r [32];
    logic [31:0] ins, simm, a, v;
    logic [5:0]  op, f;
    logic [4:0]  rs, rt, d;
    int idx, nxt;
    bit w;
    for (int i = 0; i < 32; i++) r[i] = '0;
    exp_a.delete(); exp_d.delete(); exp_n = 0; idx = 0;
    for (int guard = 0; guard < 1000; guard++) begin
      ins = imem[idx];
      exp_n++;
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; f = ins[5:0];
      simm = {{16{ins[15]}}, ins[15:0]};
      w = 1'b0; d = rt; v = '0; nxt = idx + 1;
      case (op)
        6'h00: begin
          d = ins[15:11];
          w = 1'b1;
          case (f)
            6'h20: v = r[rs] + r[rt];
            6'h22: v = r[rs] - r[rt];
            6'h24: v = r[rs] & r[rt];
            6'h25: v = r[rs] | r[rt];
            6'h2A: v = ($signed(r[rs]) < $signed(r[rt])) ? 32'd1 : 32'd0;
            default: w = 1'b0;
          endcase
        end
        6'h08: begin w = 1'b1; v = r[rs] + simm; end
        6'h23: begin w = 1'b1; a = r[rs] + simm; v = ref_mem[(a >> 2) % 256]; end
        6'h2B: begin a = r[rs] + simm; ref_mem[(a >> 2) % 256] = r[rt]; end
        6'h04: if (r[rs] == r[rt]) nxt = idx + 1 + int'($signed(simm));
        6'h05: if (r[rs] != r[rt]) nxt = idx + 1 + int'($signed(simm));
        default: ;
      endcase
      if (w && d != 5'd0) begin
        r[d] = v;
        exp_a.push_back(int'(d));
        exp_d.push_back(int'(v));
      end
      if (idx == L) break;
      idx = nxt;
    end
  endtask

  task automatic gen_prog();
    int sel, k;
    logic [5:0] fns [5];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
    for (int i = 0; i < L; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 25) imem[i] = i_ins(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
      else if (sel < 60) imem[i] = r_ins(fns[$urandom_range(0, 4)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      else if (sel < 72) imem[i] = i_ins(6'h23, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'(4 * $urandom_range(0, 31)));
      else if (sel < 84) imem[i] = i_ins(6'h2B, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'(4 * $urandom_range(0, 31)));
      else if (sel < 94) begin
        k = $urandom_range(0, (L - 1 - i) < 3 ? L - 1 - i : 3);
        imem[i] = i_ins(sel < 89 ? 6'h04 : 6'h05, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'(k));
      end
      else if (sel < 97) imem[i] = {6'h3F, 26'($urandom)};
      else imem[i] = r_ins(6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    imem[L] = i_ins(6'h08, 5'd31, 5'd0, 16'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, diff;
    // forwarding chain
    prep();
    imem[0] = i_ins(6'h08, 5'd1, 5'd0, 16'd5);
    imem[1] = r_ins(6'h20, 5'd2, 5'd1, 5'd1);
    imem[2] = r_ins(6'h22, 5'd3, 5'd2, 5'd1);
    start(); run(16);
    check("chain_nwr", log_a.size(), 3);
    exp_wr("chain0", 0, 1, 5, 5);
    exp_wr("chain1", 1, 2, 10, FWD ? 6 : 8);
    exp_wr("chain2", 2, 3, 5, FWD ? 7 : 11);
    // load-use
    prep();
    imem[0] = i_ins(6'h08, 5'd1, 5'd0, 16'd7);
    imem[1] = i_ins(6'h2B, 5'd1, 5'd0, 16'd4);
    imem[2] = i_ins(6'h23, 5'd4, 5'd0, 16'd4);
    imem[3] = r_ins(6'h20, 5'd5, 5'd4, 5'd4);
    start(); run(18);
    check("lu_nwr", log_a.size(), 3);
    exp_wr("lu0", 0, 1, 7, 5);
    exp_wr("lu1", 1, 4, 7, FWD ? 7 : 9);
    exp_wr("lu2", 2, 5, 14, FWD ? 9 : 12);
    check("lu_mem", dmem[1], 32'd7);
    // taken branch flushes two shadow instructions
    prep();
    imem[0] = i_ins(6'h04, 5'd0, 5'd0, 16'd2);
    imem[1] = i_ins(6'h08, 5'd1, 5'd0, 16'd1);
    imem[2] = i_ins(6'h08, 5'd2, 5'd0, 16'd2);
    imem[3] = i_ins(6'h08, 5'd3, 5'd0, 16'd3);
    start(); run(12);
    check("br_nwr", log_a.size(), 1);
    exp_wr("br0", 0, 3, 3, 8);
    check("br_retire", log_r.size() > 0 ? log_r[0] : -1, 1);
    // not-taken branch
    prep();
    imem[0] = i_ins(6'h05, 5'd0, 5'd0, 16'd2);
    imem[1] = i_ins(6'h08, 5'd1, 5'd0, 16'd1);
    imem[2] = i_ins(6'h08, 5'd2, 5'd0, 16'd2);
    start(); run(12);
    check("nt_nwr", log_a.size(), 2);
    exp_wr("nt0", 0, 1, 1, 6);
    exp_wr("nt1", 1, 2, 2, 7);
    check("nt_retire", log_r.size() > 1 ? log_r[1] : -1, 2);
    // writes to r0
    prep();
    imem[0] = i_ins(6'h08, 5'd0, 5'd0, 16'd9);
    imem[1] = i_ins(6'h08, 5'd6, 5'd0, 16'd3);
    start(); run(10);
    check("r0_nwr", log_a.size(), 1);
    exp_wr("r0", 0, 6, 3, 6);
    // reset while a store sits in EX
    prep();
    imem[0] = i_ins(6'h08, 5'd1, 5'd0, 16'd7);
    imem[1] = i_ins(6'h2B, 5'd1, 5'd0, 16'd8);
    imem[2] = i_ins(6'h08, 5'd2, 5'd0, 16'd5);
    we0 = we_cnt;
    start(); run(FWD ? 3 : 5);
    reset = 1'b1;
    #1;
    check("mid_imem_addr", imem_addr, 8'd0);
    check("mid_retire", retire_cnt, 32'd0);
    check("mid_we", dmem_we, 1'b0);
    run(2);
    check("mid_we_cnt", we_cnt - we0, 0);
    check("mid_mem", dmem[2], 32'd0);
    start(); run(14);
    check("rerun_nwr", log_a.size(), 2);
    exp_wr("rerun0", 0, 1, 7, 5);
    exp_wr("rerun1", 1, 2, 5, FWD ? 7 : 9);
    check("rerun_mem", dmem[2], 32'd7);
    check("rerun_we_cnt", we_cnt - we0, 1);
    // random programs against the ISA model
    for (int t = 0; t < 40; t++) begin
      prep();
      gen_prog();
      for (int i = 0; i < 256; i++) begin
        dmem[i] = $urandom;
        ref_mem[i] = dmem[i];
      end
      ref_run();
      start();
      for (int k = 0; k < 400 && !mark_seen; k++) @(negedge clock);
      check($sformatf("rnd%0d_marker", t), mark_seen, 1'b1);
      run(3);
      check($sformatf("rnd%0d_nwr", t), log_a.size(), exp_a.size());
      for (int i = 0; i < exp_a.size(); i++) begin
        check($sformatf("rnd%0d_w%0d_addr", t, i), i < log_a.size() ? log_a[i] : -1, exp_a[i]);
        check($sformatf("rnd%0d_w%0d_data", t, i), i < log_d.size() ? log_d[i] : -1, exp_d[i]);
      end
      check($sformatf("rnd%0d_retire", t), log_r.size() > 0 ? log_r[log_r.size() - 1] + 1 : -1, exp_n);
      diff = 0;
      for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) diff++;
      check($sformatf("rnd%0d_dmem_diffs", t), diff, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
